// File: rtl/pipe_hazard_chain_if.sv
// Handshake, forwarding-query and output bundle of the in-order hazard-aware pipeline chain.
interface pipe_hazard_chain_if #(
   parameter int STAGES = 3,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NSRC   = 2
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        in_data;
   logic                     in_wr_en;
   logic [ADDR_W-1:0]        in_wr_addr;
   logic                     in_res_rdy;
   logic [DATA_W-1:0]        in_res_data;
   logic                     upd_valid;
   logic [DATA_W-1:0]        upd_data;
   logic [STAGES:0]          flush_mask;
   logic [NSRC-1:0]          qry_en;
   logic [NSRC*ADDR_W-1:0]   qry_addr;
   logic [NSRC-1:0]          fwd_hit;
   logic [NSRC*DATA_W-1:0]   fwd_data;
   logic                     hazard;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_W-1:0]        out_data;
   logic                     out_wr_en;
   logic [ADDR_W-1:0]        out_wr_addr;
   logic [DATA_W-1:0]        out_res_data;
   logic [15:0]              hazard_cnt;

   modport master (
      output in_valid, in_data, in_wr_en, in_wr_addr, in_res_rdy, in_res_data,
             upd_valid, upd_data, flush_mask, qry_en, qry_addr, out_ready,
      input  in_ready, fwd_hit, fwd_data, hazard, out_valid, out_data, out_wr_en,
             out_wr_addr, out_res_data, hazard_cnt
   );

   modport slave (
      input  in_valid, in_data, in_wr_en, in_wr_addr, in_res_rdy, in_res_data,
             upd_valid, upd_data, flush_mask, qry_en, qry_addr, out_ready,
      output in_ready, fwd_hit, fwd_data, hazard, out_valid, out_data, out_wr_en,
             out_wr_addr, out_res_data, hazard_cnt
   );
endinterface

// File: rtl/pipe_hazard_chain.sv
// In-order pipeline register chain with backpressure, per-stage flush, load-use bubbles,
// youngest-first operand forwarding and a late-result update port. State changes on the falling edge.
module pipe_hazard_chain #(
   parameter int STAGES    = 3,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 3,
   parameter int NSRC      = 2,
   parameter int MEM_STAGE = 1
) (
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_chain_if.slave bus
);
   typedef struct packed {
      logic              vld;
      logic              wen;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] data;
      logic              rrdy;
      logic [DATA_W-1:0] res;
   } ent_t;

   // Where a late result lands when the chain advances; entries leaving the chain are not updated.
   localparam int  UPD_ADV = (MEM_STAGE < STAGES-1) ? MEM_STAGE+1 : MEM_STAGE;
   localparam bit  UPD_CAN_ADV = (MEM_STAGE < STAGES-1);

   ent_t [STAGES-1:0] st_q, st_d;
   logic [15:0]       hcnt_q, hcnt_d;
   logic              stall, haz, accept, upd_hit;
   ent_t              in_ent;

   assign stall            = st_q[STAGES-1].vld & ~bus.out_ready;
   assign accept           = bus.in_valid & bus.in_ready;
   assign upd_hit          = bus.upd_valid & st_q[MEM_STAGE].vld & ~st_q[MEM_STAGE].rrdy;

   assign bus.in_ready     = ~stall & ~haz;
   assign bus.hazard       = haz;
   assign bus.out_valid    = st_q[STAGES-1].vld;
   assign bus.out_data     = st_q[STAGES-1].data;
   assign bus.out_wr_en    = st_q[STAGES-1].wen;
   assign bus.out_wr_addr  = st_q[STAGES-1].waddr;
   assign bus.out_res_data = st_q[STAGES-1].res;
   assign bus.hazard_cnt   = hcnt_q;

   // Forwarding scans oldest to youngest so the youngest matching producer overrides.
   always_comb begin
      logic              fnd;
      logic              frdy;
      logic [DATA_W-1:0] fres;
      haz          = 1'b0;
      bus.fwd_hit  = '0;
      bus.fwd_data = '0;
      for (int i = 0; i < NSRC; i++) begin
         fnd  = 1'b0;
         frdy = 1'b0;
         fres = '0;
         for (int k = STAGES-1; k >= 0; k--) begin
            if (st_q[k].vld && st_q[k].wen &&
                st_q[k].waddr == bus.qry_addr[i*ADDR_W +: ADDR_W]) begin
               fnd  = 1'b1;
               frdy = st_q[k].rrdy;
               fres = st_q[k].res;
            end
         end
         if (bus.qry_en[i] && fnd) begin
            if (frdy) begin
               bus.fwd_hit[i]                    = 1'b1;
               bus.fwd_data[i*DATA_W +: DATA_W] = fres;
            end else begin
               haz = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ent       = '0;
      in_ent.vld   = accept & ~bus.flush_mask[0];
      in_ent.wen   = bus.in_wr_en;
      in_ent.waddr = bus.in_wr_addr;
      in_ent.data  = bus.in_data;
      in_ent.rrdy  = bus.in_res_rdy;
      in_ent.res   = bus.in_res_data;

      st_d = st_q;
      if (stall) begin
         for (int k = 0; k < STAGES; k++)
            st_d[k].vld = st_q[k].vld & ~bus.flush_mask[k+1];
         if (upd_hit) begin
            st_d[MEM_STAGE].res  = bus.upd_data;
            st_d[MEM_STAGE].rrdy = 1'b1;
         end
      end else begin
         st_d[0] = in_ent;
         for (int k = 1; k < STAGES; k++) begin
            st_d[k]     = st_q[k-1];
            st_d[k].vld = st_q[k-1].vld & ~bus.flush_mask[k];
         end
         if (upd_hit && UPD_CAN_ADV) begin
            st_d[UPD_ADV].res  = bus.upd_data;
            st_d[UPD_ADV].rrdy = 1'b1;
         end
      end

      hcnt_d = hcnt_q;
      if (haz && bus.in_valid && hcnt_q != 16'hFFFF)
         hcnt_d = hcnt_q + 16'd1;
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= '0;
         hcnt_q <= '0;
      end else begin
         st_q   <= st_d;
         hcnt_q <= hcnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_chain.sv
// Scoreboard bench for pipe_hazard_chain: expected output entries queued at acceptance, popped on output.
module tb_pipe_hazard_chain;
   localparam int STAGES = 3, DATA_W = 16, ADDR_W = 3, NSRC = 2, MEM_STAGE = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   typedef logic [35:0] exp_t;  // {wr_en, wr_addr, data, res}
   exp_t sb[$];

   pipe_hazard_chain_if #(.STAGES(STAGES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC)) bus ();

   pipe_hazard_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC),
                       .MEM_STAGE(MEM_STAGE)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // DUT state moves on negedge; outputs are sampled on the posedge in between.
   always @(posedge clk) begin : mon
      exp_t e;
      if (mon_en && rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) chk("out_unexpected", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            chk("out_entry", {bus.out_wr_en, bus.out_wr_addr, bus.out_data, bus.out_res_data}, e);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.in_wr_en    = 1'b0;
      bus.in_wr_addr  = '0;
      bus.in_res_rdy  = 1'b0;
      bus.in_res_data = '0;
      bus.upd_valid   = 1'b0;
      bus.upd_data    = '0;
      bus.flush_mask  = '0;
      bus.qry_en      = '0;
      bus.qry_addr    = '0;
   endtask

   task automatic send(input logic [15:0] d, input logic [2:0] a, input logic rr, input logic [15:0] r);
      bus.in_valid    = 1'b1;
      bus.in_data     = d;
      bus.in_wr_en    = 1'b1;
      bus.in_wr_addr  = a;
      bus.in_res_rdy  = rr;
      bus.in_res_data = r;
   endtask

   initial begin
      idle();
      bus.out_ready = 1'b1;
      repeat (2) tick();
      bus.qry_en = 2'b11;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_hazard", bus.hazard, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_fwd_hit", bus.fwd_hit, 0);
      chk("rst_hcnt", bus.hazard_cnt, 0);
      idle();
      rst = 1'b1;
      mon_en = 1'b1;
      tick();

      // 1: stream A..D
      for (int i = 0; i < 4; i++) begin
         send(16'hA0 + 16'(i), 3'(i+1), 1'b1, 16'h11 * 16'(i+1));
         sb.push_back({1'b1, 3'(i+1), 16'hA0 + 16'(i), 16'h11 * 16'(i+1)});
         #1;
         chk("t1_in_ready", bus.in_ready, 1);
         chk("t1_out_valid", bus.out_valid, (i >= 3) ? 1 : 0);
         tick();
      end
      idle();
      repeat (4) tick();
      chk("t1_drain", sb.size(), 0);

      // 2: forwarding, youngest producer wins
      send(16'h2000, 3'd2, 1'b1, 16'h1234); sb.push_back({1'b1, 3'd2, 16'h2000, 16'h1234}); tick();
      send(16'h2001, 3'd2, 1'b1, 16'h5678); sb.push_back({1'b1, 3'd2, 16'h2001, 16'h5678}); tick();
      idle();
      bus.qry_en = 2'b11;
      bus.qry_addr = {3'd7, 3'd2};
      #1;
      chk("t2_hit0", bus.fwd_hit[0], 1);
      chk("t2_data0", bus.fwd_data[15:0], 16'h5678);
      chk("t2_hit1_miss", bus.fwd_hit[1], 0);
      chk("t2_data1_miss", bus.fwd_data[31:16], 0);
      chk("t2_hazard", bus.hazard, 0);
      tick();
      chk("t2_data0_adv", bus.fwd_data[15:0], 16'h5678);
      idle();
      repeat (3) tick();
      chk("t2_drain", sb.size(), 0);

      // 3: load-use hazard and late update
      send(16'h5500, 3'd5, 1'b0, 16'h0000); sb.push_back({1'b1, 3'd5, 16'h5500, 16'hBEEF}); tick();
      send(16'h6600, 3'd6, 1'b1, 16'h0066);
      bus.qry_en = 2'b01;
      bus.qry_addr = {3'd0, 3'd5};
      #1;
      chk("t3_hazard", bus.hazard, 1);
      chk("t3_in_ready", bus.in_ready, 0);
      chk("t3_hit0", bus.fwd_hit[0], 0);
      tick();
      chk("t3_hcnt1", bus.hazard_cnt, 1);
      chk("t3_hazard_s1", bus.hazard, 1);
      bus.upd_valid = 1'b1;
      bus.upd_data = 16'hBEEF;
      #1;
      chk("t3_in_ready_s1", bus.in_ready, 0);
      tick();
      bus.upd_valid = 1'b0;
      #1;
      chk("t3_hazard_clr", bus.hazard, 0);
      chk("t3_fwd_hit", bus.fwd_hit[0], 1);
      chk("t3_fwd_data", bus.fwd_data[15:0], 16'hBEEF);
      chk("t3_in_ready_go", bus.in_ready, 1);
      chk("t3_hcnt2", bus.hazard_cnt, 2);
      sb.push_back({1'b1, 3'd6, 16'h6600, 16'h0066});
      tick();
      idle();
      repeat (4) tick();
      chk("t3_drain", sb.size(), 0);

      // 4: backpressure with full chain
      for (int i = 0; i < 3; i++) begin
         send(16'h4000 + 16'(i), 3'(i), 1'b1, 16'h0400 + 16'(i));
         sb.push_back({1'b1, 3'(i), 16'h4000 + 16'(i), 16'h0400 + 16'(i)});
         tick();
      end
      bus.out_ready = 1'b0;
      send(16'h4003, 3'd3, 1'b1, 16'h0403);
      #1;
      chk("t4_in_ready", bus.in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_hold_valid", bus.out_valid, 1);
         chk("t4_hold_data", bus.out_data, 16'h4000);
         chk("t4_hold_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      sb.push_back({1'b1, 3'd3, 16'h4003, 16'h0403});
      #1;
      chk("t4_release", bus.in_ready, 1);
      tick();
      idle();
      repeat (4) tick();
      chk("t4_drain", sb.size(), 0);

      // 5: flush incoming and stage 0 while stage 1 advances to output
      send(16'h5001, 3'd1, 1'b1, 16'h0501); sb.push_back({1'b1, 3'd1, 16'h5001, 16'h0501}); tick();
      send(16'h5002, 3'd2, 1'b1, 16'h0502); tick();
      send(16'h5003, 3'd3, 1'b1, 16'h0503);
      bus.flush_mask = 4'b0011;
      #1;
      chk("t5_in_ready", bus.in_ready, 1);
      tick();
      idle();
      chk("t5_out_valid", bus.out_valid, 1);
      chk("t5_out_data", bus.out_data, 16'h5001);
      tick();
      chk("t5_bubble", bus.out_valid, 0);
      repeat (2) tick();
      chk("t5_empty", bus.out_valid, 0);
      chk("t5_drain", sb.size(), 0);

      // 5b: flush of the output entry during a stall
      send(16'h5101, 3'd1, 1'b1, 16'h0511); tick();
      send(16'h5102, 3'd2, 1'b1, 16'h0512); sb.push_back({1'b1, 3'd2, 16'h5102, 16'h0512}); tick();
      send(16'h5103, 3'd3, 1'b1, 16'h0513); sb.push_back({1'b1, 3'd3, 16'h5103, 16'h0513}); tick();
      idle();
      bus.out_ready = 1'b0;
      bus.flush_mask = 4'b1000;
      #1;
      chk("t5b_pre", bus.out_valid, 1);
      tick();
      bus.flush_mask = '0;
      chk("t5b_killed", bus.out_valid, 0);
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("t5b_drain", sb.size(), 0);

      // 6: reset mid-stream with a pending hazard
      send(16'h6001, 3'd3, 1'b0, 16'h0000); tick();
      send(16'h6002, 3'd4, 1'b1, 16'h0602); tick();
      send(16'h6003, 3'd5, 1'b1, 16'h0603); tick();
      bus.out_ready = 1'b0;
      send(16'h6004, 3'd6, 1'b1, 16'h0604);
      bus.qry_en = 2'b01;
      bus.qry_addr = {3'd0, 3'd3};
      #1;
      chk("t6_hazard", bus.hazard, 1);
      tick();
      chk("t6_hcnt", bus.hazard_cnt, 3);
      #1;
      rst = 1'b0;
      #1;
      chk("t6_out_valid", bus.out_valid, 0);
      chk("t6_hazard_rst", bus.hazard, 0);
      chk("t6_in_ready", bus.in_ready, 1);
      chk("t6_hcnt_rst", bus.hazard_cnt, 0);
      chk("t6_fwd_hit", bus.fwd_hit, 0);
      idle();
      sb.delete();
      tick();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      send(16'h7777, 3'd7, 1'b1, 16'h0777); sb.push_back({1'b1, 3'd7, 16'h7777, 16'h0777}); tick();
      idle();
      repeat (4) tick();
      chk("t6_post_drain", sb.size(), 0);
      chk("t6_post_hcnt", bus.hazard_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
